slice_sequencer: RTL and testbench
==================================

Name: slice_sequencer

Overview:
Controller that sequences one slicing job: mover stepper advance, then cutter handshake, repeated until the object is in slice_num_i pieces.
Sits between the debounced start/pause keys, the measured object length from the ultrasonic path, the mover coil outputs, and the cutter motor driver.
Computes steps-per-slice with an internal sequential divider, then runs MOVE/CUT cycles with pause support.

Parameters:
SPEED_DIV, 50000, clk cycles per mover step (1 kHz at 50 MHz); must be >= 2
STEPS_PER_MM, 5, mover full steps per mm of travel (1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  one-cycle pulse; begin a job
pause_i  in  1  one-cycle pulse; toggles pause while busy
slice_num_i  in  5  requested pieces, sampled on accepted start
length_i  in  16  object length in mm, sampled on accepted start
move_phase_o  out  4  mover coil pattern, one-hot full step
cut_req_o  out  1  level request to cutter driver
cut_done_i  in  1  cutter finished one stroke, sampled only in CUT
slice_cnt_o  out  5  cuts completed in current job
busy_o  out  1  high in any state other than IDLE
paused_o  out  1  pause flag
finish_o  out  1  one-cycle pulse on job completion
err_o  out  1  one-cycle pulse on rejected job

Behaviour:
- Reset values: all outputs 0; state IDLE; internal phase register 4'b0001; slice_cnt_o 0.
- States: IDLE, DIV, MOVE, CUT, DONE.
- IDLE:
  - On start_i: if slice_num_i==0 or length_i==0, pulse err_o and stay in IDLE.
  - Otherwise latch N=slice_num_i and total=length_i*STEPS_PER_MM (24-bit, unsigned), clear slice_cnt_o, and go to DIV.
  - pause_i is ignored in IDLE. paused_o is cleared on every entry to IDLE.
- DIV:
  - Restoring division total/N, one quotient bit per cycle, exactly 24 cycles. Remainder is discarded.
  - Afterwards: if Q==0, pulse err_o and go to IDLE. Else if N==1, go to DONE. Else go to MOVE with step counter 0 and step timer 0.
- MOVE (not paused):
  - The timer counts 0..SPEED_DIV-1. At terminal count the phase rotates left (0001->0010->0100->1000->0001) and the step counter increments.
  - move_phase_o equals the phase register in MOVE when not paused, else 0000.
  - When the step counter reaches Q: go to CUT the next cycle. Phase register is retained.
- MOVE (paused): timer, step counter and phase are frozen; move_phase_o=0000.
- CUT:
  - cut_req_o=1 throughout the state.
  - On the first cycle with cut_done_i=1: cut_req_o drops the next cycle and slice_cnt_o increments.
  - If the new slice_cnt_o equals N-1, go to DONE. Else go to MOVE with counters cleared.
  - Pause does not interrupt CUT. A pause toggled in CUT takes effect on entry to MOVE.
- DONE: pulse finish_o for 1 cycle, then go to IDLE. slice_cnt_o holds its value until the next accepted start.
- pause_i while busy toggles paused_o (1-cycle update).
- start_i while busy is ignored.
- start_i and pause_i in the same IDLE cycle: start is accepted, pause is ignored.
- cut_done_i outside CUT is ignored.
- Latency from start_i to the first phase change: 1 latch cycle + 24 DIV cycles + SPEED_DIV cycles.
- rst at any time: immediate return to reset values. cut_req_o and move_phase_o drop asynchronously.

Test Plan:
- SPEED_DIV=4, STEPS_PER_MM=2; start with len=10, N=2 -> Q=10; 10 phase advances 4 cycles apart; cut_req_o=1; cut_done_i after 3 cycles -> slice_cnt_o=1, finish_o pulse, busy_o=0; cut_req asserted exactly once.
- len=7, N=3 -> Q=4; sequence MOVE(4 steps), CUT, MOVE(4), CUT -> finish_o; slice_cnt_o=2; 8 phase advances total.
- Same as the first scenario, with pause_i after 3 steps, held paused 20 cycles, then pause_i again -> move_phase_o=0000 and no advance while paused; total steps still 10; paused_o toggles 1->0.
- start with N=0 -> err_o pulse, busy_o stays 0. len=1, N=5 (Q=0) -> err_o pulse after 24 DIV cycles, no phase/cut activity.
- N=1, len=10 -> finish_o pulse, no MOVE, cut_req_o never asserted, slice_cnt_o=0.
- Assert rst while in CUT with cut_req_o=1 -> cut_req_o, busy_o, slice_cnt_o all 0 immediately. Second start_i pulse while busy -> ignored, job result unchanged.

Source files
------------

// File: rtl/slice_sequencer.sv
// Slicing job sequencer: derives steps-per-slice with a serial restoring divider,
// then alternates mover stepping and cutter handshakes until the object is in N pieces.
module slice_sequencer #(
  parameter int SPEED_DIV    = 50000,
  parameter int STEPS_PER_MM = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic [4:0]  slice_num_i,
  input  logic [15:0] length_i,
  output logic [3:0]  move_phase_o,
  output logic        cut_req_o,
  input  logic        cut_done_i,
  output logic [4:0]  slice_cnt_o,
  output logic        busy_o,
  output logic        paused_o,
  output logic        finish_o,
  output logic        err_o
);

  localparam int TW = $clog2(SPEED_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(SPEED_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_MOVE, S_CUT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [4:0]    slice_q, slice_d;
  logic          paused_q, paused_d;
  logic          busy_q, busy_d;
  logic          cut_req_q, cut_req_d;
  logic          finish_q, finish_d;
  logic          err_q, err_d;
  logic [3:0]    move_phase_q, move_phase_d;

  logic [4:0]    n_q, n_d;
  logic [23:0]   quo_q, quo_d;
  logic [23:0]   rem_q, rem_d;
  logic [4:0]    div_cnt_q, div_cnt_d;
  logic [23:0]   step_q, step_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [24:0]   shifted;
  logic [24:0]   trial;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    slice_d   = slice_q;
    paused_d  = paused_q;
    err_d     = 1'b0;
    n_d       = n_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    step_d    = step_q;
    timer_d   = timer_q;
    // Remainder never exceeds N-1, so bit 24 of trial acts as the borrow.
    shifted   = {rem_q, quo_q[23]};
    trial     = shifted - {20'd0, n_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (slice_num_i == 5'd0 || length_i == 16'd0) begin
            err_d = 1'b1;
          end else begin
            n_d       = slice_num_i;
            quo_d     = 24'(length_i) * 24'(STEPS_PER_MM);
            rem_d     = '0;
            div_cnt_d = '0;
            slice_d   = '0;
            state_d   = S_DIV;
          end
        end
      end
      S_DIV: begin
        if (!trial[24]) begin
          rem_d = trial[23:0];
          quo_d = {quo_q[22:0], 1'b1};
        end else begin
          rem_d = shifted[23:0];
          quo_d = {quo_q[22:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd23) begin
          if (quo_d == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (n_q == 5'd1) begin
            state_d = S_DONE;
          end else begin
            step_d  = '0;
            timer_d = '0;
            state_d = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (!paused_q) begin
          if (step_q == quo_q) begin
            state_d = S_CUT;
          end else if (timer_q == T_LAST) begin
            timer_d = '0;
            step_d  = step_q + 24'd1;
            phase_d = {phase_q[2:0], phase_q[3]};
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_CUT: begin
        if (cut_done_i) begin
          slice_d = slice_q + 5'd1;
          if (slice_d == n_q - 5'd1) begin
            state_d = S_DONE;
          end else begin
            step_d  = '0;
            timer_d = '0;
            state_d = S_MOVE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pause_i && state_q != S_IDLE) paused_d = !paused_q;
    if (state_d == S_IDLE) paused_d = 1'b0;

    busy_d       = (state_d != S_IDLE);
    cut_req_d    = (state_d == S_CUT);
    finish_d     = (state_d == S_DONE);
    move_phase_d = (state_d == S_MOVE && !paused_d) ? phase_d : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 4'b0001;
      slice_q      <= '0;
      paused_q     <= 1'b0;
      busy_q       <= 1'b0;
      cut_req_q    <= 1'b0;
      finish_q     <= 1'b0;
      err_q        <= 1'b0;
      move_phase_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      slice_q      <= slice_d;
      paused_q     <= paused_d;
      busy_q       <= busy_d;
      cut_req_q    <= cut_req_d;
      finish_q     <= finish_d;
      err_q        <= err_d;
      move_phase_q <= move_phase_d;
    end
  end

  // Divider and step counters are always initialised on entry, so they need no reset.
  always_ff @(posedge clk) begin
    n_q       <= n_d;
    quo_q     <= quo_d;
    rem_q     <= rem_d;
    div_cnt_q <= div_cnt_d;
    step_q    <= step_d;
    timer_q   <= timer_d;
  end

  assign move_phase_o = move_phase_q;
  assign cut_req_o    = cut_req_q;
  assign slice_cnt_o  = slice_q;
  assign busy_o       = busy_q;
  assign paused_o     = paused_q;
  assign finish_o     = finish_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Bench for slice_sequencer: directed and random jobs, each compared against a
// job-level model (quotient, advances, cuts, final count) computed from plain arithmetic.
module tb_slice_sequencer;
  localparam int SD  = 4;
  localparam int SPM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        pause_i = 1'b0;
  logic        cut_done_i = 1'b0;
  logic [4:0]  slice_num_i = '0;
  logic [15:0] length_i = '0;
  logic [3:0]  move_phase_o;
  logic        cut_req_o;
  logic [4:0]  slice_cnt_o;
  logic        busy_o, paused_o, finish_o, err_o;

  int checks = 0;
  int failures = 0;
  int prev_slice = 0;

  int obs_adv, obs_cuts, obs_fin, obs_err, obs_err_edge, obs_fin_slice, obs_first;
  int obs_min_gap, obs_bad_rot, obs_pviol, obs_adv_paused, obs_paused_ever;
  int obs_busy_ever, obs_timeout, obs_slice_end, obs_busy_end, obs_paused_mid, obs_fin_paused;

  slice_sequencer #(.SPEED_DIV(SD), .STEPS_PER_MM(SPM)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i),
    .slice_num_i(slice_num_i), .length_i(length_i), .move_phase_o(move_phase_o),
    .cut_req_o(cut_req_o), .cut_done_i(cut_done_i), .slice_cnt_o(slice_cnt_o),
    .busy_o(busy_o), .paused_o(paused_o), .finish_o(finish_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one job cycle by cycle, acting as cutter and pause operator, recording events.
  task automatic run_job(input int len, input int n, input int cd, input int pause_after,
                         input int pause_len, input bit dup, input bit pws);
    int edges = 0, req_cycles = 0, last_nz = 0, t_last = 0, pstate = 0, ptimer = 0, tail = -1;
    bit prev_req = 1'b0, done = 1'b0;
    obs_adv = 0; obs_cuts = 0; obs_fin = 0; obs_err = 0; obs_err_edge = -1;
    obs_fin_slice = -1; obs_first = -1; obs_min_gap = 1000000; obs_bad_rot = 0;
    obs_pviol = 0; obs_adv_paused = 0; obs_paused_ever = 0; obs_busy_ever = 0;
    obs_paused_mid = 0; obs_fin_paused = 0;
    @(negedge clk);
    length_i = 16'(len); slice_num_i = 5'(n); start_i = 1'b1; pause_i = pws;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      @(negedge clk);
      edges++;
      start_i = 1'b0; pause_i = 1'b0; cut_done_i = 1'b0;
      if (move_phase_o != 4'b0000) begin
        if (!$onehot(move_phase_o)) obs_bad_rot++;
        if (last_nz != 0 && int'(move_phase_o) != last_nz) begin
          if (move_phase_o != rotl(4'(last_nz))) obs_bad_rot++;
          obs_adv++;
          if (pstate == 1) obs_adv_paused++;
          if (obs_adv == 1) obs_first = edges;
          else if (edges - t_last < obs_min_gap) obs_min_gap = edges - t_last;
          t_last = edges;
        end
        last_nz = int'(move_phase_o);
      end
      if (paused_o) begin
        obs_paused_ever = 1;
        if (move_phase_o != 4'b0000) obs_pviol++;
      end
      if (busy_o) obs_busy_ever = 1;
      if (cut_req_o && !prev_req) obs_cuts++;
      prev_req = cut_req_o;
      if (finish_o) begin
        obs_fin++;
        obs_fin_slice = int'(slice_cnt_o);
        obs_fin_paused = int'(paused_o);
      end
      if (err_o) begin
        obs_err++;
        if (obs_err_edge < 0) obs_err_edge = edges;
      end
      if ((finish_o || err_o) && tail < 0) tail = 3;
      else if (tail > 0) begin
        tail--;
        if (tail == 0) done = 1'b1;
      end
      if (cut_req_o) begin
        req_cycles++;
        if (req_cycles == cd) cut_done_i = 1'b1;
      end else begin
        req_cycles = 0;
      end
      if (pstate == 0 && pause_after > 0 && obs_adv == pause_after) begin
        pause_i = 1'b1; pstate = 1; ptimer = 0;
      end else if (pstate == 1) begin
        ptimer++;
        if (ptimer == 10) obs_paused_mid = int'(paused_o);
        if (ptimer == pause_len) begin
          pause_i = 1'b1; pstate = 2;
        end
      end
      if (dup && edges == 30) begin
        start_i = 1'b1; length_i = 16'(len + 7); slice_num_i = 5'(n + 1);
      end
    end
    obs_timeout   = done ? 0 : 1;
    obs_slice_end = int'(slice_cnt_o);
    obs_busy_end  = int'(busy_o);
  endtask

  // Job-level model: quotient from plain division, then count events the job must produce.
  task automatic check_job(input string tag, input int len, input int n);
    int q = 0, e_adv = 0, e_cuts = 0, e_fin = 0, e_err = 0, e_err_edge = -1, e_slice, e_busy = 1;
    if (n == 0 || len == 0) begin
      e_err = 1; e_err_edge = 1; e_slice = prev_slice; e_busy = 0;
    end else begin
      q = (len * SPM) / n;
      if (q == 0) begin
        e_err = 1; e_err_edge = 25; e_slice = 0;
      end else begin
        e_fin = 1; e_slice = n - 1; e_cuts = n - 1; e_adv = q * (n - 1);
      end
    end
    chk($sformatf("%s_timeout", tag), obs_timeout, 0);
    chk($sformatf("%s_advances", tag), obs_adv, e_adv);
    chk($sformatf("%s_cut_reqs", tag), obs_cuts, e_cuts);
    chk($sformatf("%s_finish", tag), obs_fin, e_fin);
    chk($sformatf("%s_err", tag), obs_err, e_err);
    chk($sformatf("%s_slice_end", tag), obs_slice_end, e_slice);
    chk($sformatf("%s_busy_end", tag), obs_busy_end, 0);
    chk($sformatf("%s_busy_seen", tag), obs_busy_ever, e_busy);
    chk($sformatf("%s_phase_seq", tag), obs_bad_rot, 0);
    chk($sformatf("%s_paused_phase", tag), obs_pviol, 0);
    if (e_err) chk($sformatf("%s_err_time", tag), obs_err_edge, e_err_edge);
    if (e_fin) begin
      chk($sformatf("%s_fin_slice", tag), obs_fin_slice, e_slice);
      chk($sformatf("%s_fin_unpaused", tag), obs_fin_paused, 0);
    end
    if (e_adv > 0) chk($sformatf("%s_first_step_lat", tag), obs_first, 25 + SD);
    if (e_adv > 1) chk($sformatf("%s_step_gap", tag), obs_min_gap, SD);
    prev_slice = e_slice;
  endtask

  initial begin
    bit found;
    int rc;
    int len, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_phase", int'(move_phase_o), 0);
    chk("rst_cut_req", int'(cut_req_o), 0);
    chk("rst_slice", int'(slice_cnt_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_paused", int'(paused_o), 0);
    chk("rst_finish", int'(finish_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst = 1'b0;

    @(negedge clk); pause_i = 1'b1;
    @(negedge clk); pause_i = 1'b0;
    @(negedge clk);
    chk("idle_pause_ignored", int'(paused_o), 0);
    chk("idle_pause_busy", int'(busy_o), 0);

    run_job(10, 2, 3, -1, 0, 1'b1, 1'b0);
    check_job("len10_n2_dupstart", 10, 2);

    run_job(7, 3, 2, -1, 0, 1'b0, 1'b0);
    check_job("len7_n3", 7, 3);

    run_job(10, 2, 3, 3, 20, 1'b0, 1'b0);
    check_job("pause", 10, 2);
    chk("pause_flag_high", obs_paused_mid, 1);
    chk("pause_no_advance", obs_adv_paused, 0);

    run_job(10, 0, 1, -1, 0, 1'b0, 1'b0);
    check_job("n0", 10, 0);
    run_job(0, 4, 1, -1, 0, 1'b0, 1'b0);
    check_job("len0", 0, 4);
    run_job(1, 5, 1, -1, 0, 1'b0, 1'b0);
    check_job("q0", 1, 5);
    run_job(10, 1, 1, -1, 0, 1'b0, 1'b0);
    check_job("n1", 10, 1);

    run_job(7, 3, 1, -1, 0, 1'b0, 1'b1);
    check_job("start_pause_same", 7, 3);
    chk("start_pause_same_unpaused", obs_paused_ever, 0);

    @(negedge clk);
    length_i = 16'd7; slice_num_i = 5'd3; start_i = 1'b1;
    found = 1'b0; rc = 0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      @(negedge clk);
      start_i = 1'b0; cut_done_i = 1'b0;
      if (cut_req_o && slice_cnt_o == 5'd1) found = 1'b1;
      else if (cut_req_o) begin
        rc++;
        if (rc == 2) cut_done_i = 1'b1;
      end else rc = 0;
    end
    chk("rst_cut_reached", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cut_req", int'(cut_req_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_slice", int'(slice_cnt_o), 0);
    chk("async_rst_phase", int'(move_phase_o), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy_o), 0);
    prev_slice = 0;

    for (int i = 0; i < 8; i++) begin
      len = int'($urandom_range(0, 40));
      n = int'($urandom_range(0, 6));
      run_job(len, n, int'($urandom_range(1, 4)), -1, 0, 1'b0, 1'b0);
      check_job($sformatf("rand%0d_len%0d_n%0d", i, len, n), len, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
